// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control: branch flush, one-cycle load-use stall, MD_LATENCY-cycle multiply/divide stall.
// Outputs are combinational from state and inputs; the stall counter saturates at 0xFFFF.
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic        ID_EX_MemRead_in,
  input  logic [4:0]  ID_EX_Rt_in,
  input  logic [4:0]  IF_ID_Rs_in,
  input  logic [4:0]  IF_ID_Rt_in,
  input  logic        branch_taken_in,
  input  logic        muldiv_start_in,
  output logic        PC_Write_out,
  output logic        IF_ID_Write_out,
  output logic        IF_ID_Flush_out,
  output logic        ID_EX_Write_out,
  output logic        ID_EX_Bubble_out,
  output logic        md_busy_out,
  output logic [15:0] stall_cycles_out
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] md_cnt;
  logic       load_use;

  // The start cycle counts toward the latency, so the busy phase runs MD_LATENCY-1 cycles.
  localparam logic [3:0] MD_CNT_INIT = 4'(MD_LATENCY - 2);

  assign load_use = ID_EX_MemRead_in && (ID_EX_Rt_in != 5'd0) &&
                    ((ID_EX_Rt_in == IF_ID_Rs_in) || (ID_EX_Rt_in == IF_ID_Rt_in));

  always_comb begin
    PC_Write_out     = 1'b1;
    IF_ID_Write_out  = 1'b1;
    IF_ID_Flush_out  = 1'b0;
    ID_EX_Write_out  = 1'b1;
    ID_EX_Bubble_out = 1'b0;
    md_busy_out      = 1'b0;
    if (reset_in) begin
      PC_Write_out     = 1'b0;
      IF_ID_Write_out  = 1'b0;
      IF_ID_Flush_out  = 1'b1;
      ID_EX_Bubble_out = 1'b1;
    end else if (state == MD_BUSY) begin
      PC_Write_out    = 1'b0;
      IF_ID_Write_out = 1'b0;
      ID_EX_Write_out = 1'b0;
      md_busy_out     = 1'b1;
    end else if (branch_taken_in) begin
      IF_ID_Flush_out  = 1'b1;
      ID_EX_Bubble_out = 1'b1;
    end else if (muldiv_start_in) begin
      PC_Write_out    = 1'b0;
      IF_ID_Write_out = 1'b0;
      ID_EX_Write_out = 1'b0;
    end else if (load_use) begin
      PC_Write_out     = 1'b0;
      IF_ID_Write_out  = 1'b0;
      ID_EX_Bubble_out = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state            <= RUN;
      md_cnt           <= 4'd0;
      stall_cycles_out <= 16'd0;
    end else begin
      if (!PC_Write_out && (stall_cycles_out != 16'hFFFF))
        stall_cycles_out <= stall_cycles_out + 16'd1;
      case (state)
        RUN: begin
          if (!branch_taken_in && muldiv_start_in) begin
            md_cnt <= MD_CNT_INIT;
            state  <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (md_cnt != 4'd0)
            md_cnt <= md_cnt - 4'd1;
          else
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations (MD_LATENCY=4).
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        ID_EX_MemRead_in;
  logic [4:0]  ID_EX_Rt_in;
  logic [4:0]  IF_ID_Rs_in;
  logic [4:0]  IF_ID_Rt_in;
  logic        branch_taken_in;
  logic        muldiv_start_in;
  logic        PC_Write_out;
  logic        IF_ID_Write_out;
  logic        IF_ID_Flush_out;
  logic        ID_EX_Write_out;
  logic        ID_EX_Bubble_out;
  logic        md_busy_out;
  logic [15:0] stall_cycles_out;

  int tests = 0;
  int fails = 0;

  // Output bundle order: PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, md_busy
  logic [5:0] outs;
  assign outs = {PC_Write_out, IF_ID_Write_out, IF_ID_Flush_out,
                 ID_EX_Write_out, ID_EX_Bubble_out, md_busy_out};

  localparam logic [5:0] O_DEF  = 6'b110100;
  localparam logic [5:0] O_RST  = 6'b001110;
  localparam logic [5:0] O_BR   = 6'b111110;
  localparam logic [5:0] O_MDST = 6'b000000;
  localparam logic [5:0] O_LU   = 6'b000110;
  localparam logic [5:0] O_BUSY = 6'b000001;

  pipeline_hazard_ctrl #(.MD_LATENCY(4)) dut (
    .clk              (clk),
    .reset_in         (reset_in),
    .ID_EX_MemRead_in (ID_EX_MemRead_in),
    .ID_EX_Rt_in      (ID_EX_Rt_in),
    .IF_ID_Rs_in      (IF_ID_Rs_in),
    .IF_ID_Rt_in      (IF_ID_Rt_in),
    .branch_taken_in  (branch_taken_in),
    .muldiv_start_in  (muldiv_start_in),
    .PC_Write_out     (PC_Write_out),
    .IF_ID_Write_out  (IF_ID_Write_out),
    .IF_ID_Flush_out  (IF_ID_Flush_out),
    .ID_EX_Write_out  (ID_EX_Write_out),
    .ID_EX_Bubble_out (ID_EX_Bubble_out),
    .md_busy_out      (md_busy_out),
    .stall_cycles_out (stall_cycles_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lu(input logic rd, input logic [4:0] ex_rt,
                        input logic [4:0] rs, input logic [4:0] rt);
    ID_EX_MemRead_in = rd;
    ID_EX_Rt_in      = ex_rt;
    IF_ID_Rs_in      = rs;
    IF_ID_Rt_in      = rt;
  endtask

  initial begin
    reset_in        = 1'b1;
    branch_taken_in = 1'b0;
    muldiv_start_in = 1'b0;
    set_lu(1'b0, 5'd0, 5'd0, 5'd0);

    // Reset behaviour
    tick();
    tick();
    chk("reset_outs", 16'(outs), 16'(O_RST));
    chk("reset_stall", stall_cycles_out, 16'd0);
    branch_taken_in = 1'b1;
    muldiv_start_in = 1'b1;
    #1;
    chk("reset_outs_inputs_ignored", 16'(outs), 16'(O_RST));
    branch_taken_in = 1'b0;
    muldiv_start_in = 1'b0;
    reset_in        = 1'b0;
    #1;
    chk("post_reset_defaults", 16'(outs), 16'(O_DEF));
    tick();
    chk("idle_defaults", 16'(outs), 16'(O_DEF));
    chk("idle_stall", stall_cycles_out, 16'd0);

    // Load-use via Rs
    set_lu(1'b1, 5'd5, 5'd5, 5'd1);
    #1;
    chk("loaduse_rs_outs", 16'(outs), 16'(O_LU));
    tick();
    chk("loaduse_rs_stall", stall_cycles_out, 16'd1);
    set_lu(1'b0, 5'd5, 5'd5, 5'd1);
    #1;
    chk("loaduse_cleared_outs", 16'(outs), 16'(O_DEF));
    tick();
    chk("loaduse_single_stall", stall_cycles_out, 16'd1);

    // Load-use via Rt
    set_lu(1'b1, 5'd7, 5'd3, 5'd7);
    #1;
    chk("loaduse_rt_outs", 16'(outs), 16'(O_LU));
    tick();
    chk("loaduse_rt_stall", stall_cycles_out, 16'd2);

    // No hazard: zero register, mismatch, MemRead low
    set_lu(1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    chk("zero_reg_outs", 16'(outs), 16'(O_DEF));
    tick();
    chk("zero_reg_stall", stall_cycles_out, 16'd2);
    set_lu(1'b1, 5'd9, 5'd3, 5'd4);
    #1;
    chk("no_match_outs", 16'(outs), 16'(O_DEF));
    set_lu(1'b0, 5'd9, 5'd9, 5'd9);
    #1;
    chk("no_memread_outs", 16'(outs), 16'(O_DEF));
    tick();
    set_lu(1'b0, 5'd0, 5'd0, 5'd0);

    // Multiply/divide: 1 start + 3 busy cycles, inputs ignored while busy
    muldiv_start_in = 1'b1;
    #1;
    chk("md_start_outs", 16'(outs), 16'(O_MDST));
    tick();
    muldiv_start_in = 1'b0;
    branch_taken_in = 1'b1;
    set_lu(1'b1, 5'd6, 5'd6, 5'd6);
    #1;
    chk("md_busy1_outs", 16'(outs), 16'(O_BUSY));
    tick();
    branch_taken_in = 1'b0;
    set_lu(1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("md_busy2_outs", 16'(outs), 16'(O_BUSY));
    tick();
    chk("md_busy3_outs", 16'(outs), 16'(O_BUSY));
    tick();
    chk("md_done_outs", 16'(outs), 16'(O_DEF));
    chk("md_stall_count", stall_cycles_out, 16'd6);

    // Simultaneous events: branch wins
    branch_taken_in = 1'b1;
    muldiv_start_in = 1'b1;
    set_lu(1'b1, 5'd8, 5'd8, 5'd2);
    #1;
    chk("simul_outs", 16'(outs), 16'(O_BR));
    tick();
    branch_taken_in = 1'b0;
    muldiv_start_in = 1'b0;
    set_lu(1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("simul_stays_run", 16'(outs), 16'(O_DEF));
    chk("simul_no_stall", stall_cycles_out, 16'd6);

    // Muldiv beats load-use
    muldiv_start_in = 1'b1;
    set_lu(1'b1, 5'd8, 5'd8, 5'd2);
    #1;
    chk("md_over_lu_outs", 16'(outs), 16'(O_MDST));
    tick();
    muldiv_start_in = 1'b0;
    set_lu(1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    tick();
    chk("md_over_lu_done", 16'(outs), 16'(O_DEF));
    chk("md_over_lu_stall", stall_cycles_out, 16'd10);

    // Reset during second busy cycle
    muldiv_start_in = 1'b1;
    tick();
    muldiv_start_in = 1'b0;
    tick();
    chk("midreset_busy2", 16'(outs), 16'(O_BUSY));
    chk("midreset_pre_stall", stall_cycles_out, 16'd12);
    reset_in = 1'b1;
    #1;
    chk("midreset_outs", 16'(outs), 16'(O_RST));
    tick();
    chk("midreset_held_outs", 16'(outs), 16'(O_RST));
    chk("midreset_stall_clear", stall_cycles_out, 16'd0);
    reset_in = 1'b0;
    #1;
    chk("midreset_release_outs", 16'(outs), 16'(O_DEF));
    tick();
    chk("midreset_after_outs", 16'(outs), 16'(O_DEF));
    chk("midreset_after_stall", stall_cycles_out, 16'd0);

    // Saturation: continuous muldiv keeps PC_Write low every cycle
    muldiv_start_in = 1'b1;
    repeat (65534) tick();
    chk("sat_fffe", stall_cycles_out, 16'hFFFE);
    tick();
    chk("sat_ffff", stall_cycles_out, 16'hFFFF);
    repeat (5) tick();
    chk("sat_hold", stall_cycles_out, 16'hFFFF);
    muldiv_start_in = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MD_LATENCY, default 4: total stall cycles for one multiply/divide, counting the start cycle; legal range 2..16.
REQ-002 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 reset_in  input  1  synchronous, active-high reset.
REQ-004 ID_EX_MemRead_in  input  1  MemRead currently held in ID/EX.
REQ-005 ID_EX_Rt_in  input  5  Rt register number currently held in ID/EX.
REQ-006 IF_ID_Rs_in, IF_ID_Rt_in  input  5 each  source register numbers of the instruction in decode.
REQ-007 branch_taken_in  input  1  a branch resolved taken in EX this cycle.
REQ-008 muldiv_start_in  input  1  a multiply/divide entered EX this cycle.
REQ-009 PC_Write_out  output  1  PC update enable.
REQ-010 IF_ID_Write_out  output  1  IF/ID load enable.
REQ-011 IF_ID_Flush_out  output  1  load a NOP into IF/ID.
REQ-012 ID_EX_Write_out  output  1  ID/EX load enable; 0 holds all ID/EX contents.
REQ-013 ID_EX_Bubble_out  output  1  when 1, ID/EX loads all seven control signals as 0.
REQ-014 md_busy_out  output  1  high while in MD_BUSY.
REQ-015 stall_cycles_out  output  16  count of cycles with PC_Write_out=0.

Function
REQ-016 The FSM SHALL have two states, RUN and MD_BUSY, plus a 4-bit down-counter md_cnt; all outputs SHALL be combinational from the state, md_cnt, reset_in and the current inputs.
REQ-017 Load-use hazard SHALL be defined as ID_EX_MemRead_in=1 and ID_EX_Rt_in!=0 and (ID_EX_Rt_in==IF_ID_Rs_in or ID_EX_Rt_in==IF_ID_Rt_in).
REQ-018 Default outputs in RUN with no event: PC_Write=1, IF_ID_Write=1, ID_EX_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0, md_busy=0.
REQ-019 In RUN, events SHALL be prioritized as branch_taken_in, then muldiv_start_in, then load-use hazard.
REQ-020 RUN with branch_taken_in=1: IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1, IF_ID_Write=1, ID_EX_Write=1; next state RUN.
REQ-021 RUN with muldiv_start_in=1 (no branch): PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, Bubble=0; md_cnt loads MD_LATENCY-2; next state MD_BUSY.
REQ-022 RUN with load-use hazard only: PC_Write=0, IF_ID_Write=0, ID_EX_Write=1, ID_EX_Bubble=1; next state RUN. The inserted bubble clears the hazard, which gives exactly one stall cycle.
REQ-023 MD_BUSY: PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, Bubble=0, Flush=0, md_busy=1; branch, muldiv_start and load-use inputs SHALL be ignored.
REQ-024 MD_BUSY with md_cnt!=0: md_cnt decrements. With md_cnt==0: next state RUN.
REQ-025 The MD_BUSY state SHALL last exactly MD_LATENCY-1 cycles, so the total stall including the start cycle is MD_LATENCY cycles.
REQ-026 stall_cycles_out SHALL increment by 1 at each edge where PC_Write_out=0 and reset_in=0, and SHALL saturate at 0xFFFF without wrapping.

Reset
REQ-027 While reset_in=1, the block SHALL drive PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Write=1, ID_EX_Bubble=1, md_busy=0.
REQ-028 At a clock edge with reset_in=1, the block SHALL set state=RUN, md_cnt=0 and stall_cycles_out=0.
REQ-029 Reset asserted during MD_BUSY SHALL abort the operation; the first cycle after reset is released SHALL show the REQ-018 defaults.

Verification
REQ-030 Load-use: MemRead=1, ID_EX_Rt=5, IF_ID_Rs=5 for one cycle, then MemRead=0 -> exactly one cycle with PC_Write=0 and Bubble=1; stall_cycles_out advances 0->1.
REQ-031 Zero-register filter: MemRead=1, ID_EX_Rt=0, IF_ID_Rt=0 -> no stall; all outputs at REQ-018 defaults.
REQ-032 Multiply/divide: MD_LATENCY=4, muldiv_start pulse -> PC_Write=0 for exactly 4 consecutive cycles, md_busy=1 for the last 3 of them, then defaults; stall_cycles_out=4.
REQ-033 Simultaneous events: branch_taken=1, muldiv_start=1 and load-use all in one RUN cycle -> Flush=1, Bubble=1, PC_Write=1; state stays RUN.
REQ-034 Mid-operation reset: reset_in=1 in the second MD_BUSY cycle -> REQ-027 outputs while reset is high; after release state=RUN, stall_cycles_out=0, md_busy=0.
REQ-035 Saturation: hold muldiv_start=1 continuously for more than 65535 stalled cycles -> stall_cycles_out stays at 0xFFFF.
